// File: rtl/rsc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// rsc_pkg - RSC encoder constants, FSM state type and BPSK mapping
// Revision: 1.0
// ---------------------------------------------------------------------
package rsc_pkg;

  localparam int W_DEFAULT   = 16;
  localparam int AMP_DEFAULT = 1024;
  localparam int TAIL_LEN    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } rsc_state_t;

  // Bit 0 maps to +amp and bit 1 to -amp. The caller narrows the result to its symbol width.
  function automatic logic signed [31:0] bpsk_map(input logic b, input int amp);
    return b ? -amp : amp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rsc_trellis_step.sv
`default_nettype none
// ---------------------------------------------------------------------
// rsc_trellis_step - one combinational step of the (7,5) RSC trellis
// Revision: 1.0
// ---------------------------------------------------------------------
module rsc_trellis_step (
  input  logic s1,
  input  logic s2,
  input  logic u,
  output logic a,
  output logic p,
  output logic ns1,
  output logic ns2
);

  assign a   = u ^ s1 ^ s2;
  assign p   = a ^ s2;
  assign ns1 = a;
  assign ns2 = s1;

endmodule
`default_nettype wire

// File: rtl/rsc_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------
// rsc_encoder - rate-1/2 (7,5) RSC encoder with 2-bit trellis termination
// and BPSK soft output. Optional: RSC_PUNCTURE_EN erases odd data parity.
// Revision: 1.0
// ---------------------------------------------------------------------
module rsc_encoder
  import rsc_pkg::*;
#(
  parameter int FRAME_LEN = 64,
  parameter int W         = W_DEFAULT,
  parameter int AMP       = AMP_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_bit,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_sys,
  output logic signed [W-1:0] out_par,
  output logic                out_tail,
  output logic                out_last,
  output logic                busy
);

  localparam int            CW       = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);
  localparam logic          LAST_TAIL = 1'(TAIL_LEN - 1);

  rsc_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          tail_idx, tail_idx_nx;
  logic          s1, s2;

  logic slot_free, accept, tail_fire, load;
  logic u, a, p, ns1, ns2, punct;
  logic signed [W-1:0] sys_sym, par_sym;

  assign slot_free = !out_valid || out_ready;
  // Held low during reset so every output reads 0 while rst_n is asserted.
  assign in_ready  = rst_n && (state != TAIL) && slot_free;
  assign accept    = in_valid && in_ready;
  assign tail_fire = (state == TAIL) && slot_free;
  assign load      = accept || tail_fire;
  assign busy      = (state != IDLE);

  // A tail input equal to s1^s2 cancels the feedback, which drives the register towards zero.
  assign u = (state == TAIL) ? (s1 ^ s2) : in_bit;

  rsc_trellis_step u_step (
    .s1  (s1),
    .s2  (s2),
    .u   (u),
    .a   (a),
    .p   (p),
    .ns1 (ns1),
    .ns2 (ns2)
  );

`ifdef RSC_PUNCTURE_EN
  assign punct = (state != TAIL) && cnt[0];
`else
  assign punct = 1'b0;
`endif

  assign sys_sym = W'(bpsk_map(u, AMP));
  assign par_sym = punct ? '0 : W'(bpsk_map(p, AMP));

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    tail_idx_nx = tail_idx;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx   = CW'(1);
          state_nx = (FRAME_LEN == 1) ? TAIL : DATA;
        end
      end
      DATA: begin
        if (accept) begin
          cnt_nx = cnt + 1'b1;
          if (cnt == LAST_CNT) state_nx = TAIL;
        end
      end
      TAIL: begin
        if (tail_fire) begin
          if (tail_idx == LAST_TAIL) begin
            state_nx    = IDLE;
            cnt_nx      = '0;
            tail_idx_nx = 1'b0;
          end else begin
            tail_idx_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tail_idx  <= 1'b0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      out_valid <= 1'b0;
      out_sys   <= '0;
      out_par   <= '0;
      out_tail  <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      tail_idx <= tail_idx_nx;
      if (load) begin
        s1        <= ns1;
        s2        <= ns2;
        out_valid <= 1'b1;
        out_sys   <= sys_sym;
        out_par   <= par_sym;
        out_tail  <= (state == TAIL);
        out_last  <= (state == TAIL) && (tail_idx == LAST_TAIL);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/rsc_encoder.md
Name: rsc_encoder

Overview:
- Rate-1/2 recursive systematic convolutional (RSC) encoder: the transmit-side counterpart of the MAP decoder datapath.
- Code: constraint length 3, feedback polynomial 7 (1+D+D^2), feedforward polynomial 5 (1+D^2), octal.
- Accepts hard bits over a valid/ready stream, encodes fixed-length frames, and appends 2 trellis-termination tail bits so every frame ends in state 0.
- Emits systematic and parity symbols as signed W-bit BPSK soft values, ready to feed the decoder or a channel model.

Parameters:
- FRAME_LEN, 64, data bits per frame; must be ≥ 1.
- W, 16, soft-symbol width in bits, signed two's complement.
- AMP, 1024, BPSK magnitude; must satisfy 0 < AMP ≤ 2^(W-1)-1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_bit is valid
- in_ready  out  1  encoder accepts in_bit this cycle
- in_bit  in  1  data bit
- out_valid  out  1  output symbol pair is valid
- out_ready  in  1  downstream accepts the symbol pair
- out_sys  out  W  systematic symbol
- out_par  out  W  parity symbol
- out_tail  out  1  current pair is a tail symbol
- out_last  out  1  current pair is the final tail symbol of the frame
- busy  out  1  frame in progress (FSM not in IDLE)

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low. While rst_n=0, all outputs are 0, the FSM is IDLE, the trellis state (s1,s2)=(0,0), the bit counter is 0, and no symbol is pending.
- Trellis step, for input u:
  - a = u^s1^s2
  - p = a^s2
  - next state (s1,s2) = (a,s1)
- BPSK mapping: bit 0 -> +AMP, bit 1 -> -AMP, sign-extended to W bits.
- Output register: one stage deep. in_ready = (fsm==IDLE or DATA) and (!out_valid or out_ready). An input handshake loads out_sys, out_par and the trellis state on the next clk edge. Latency is 1 cycle, and throughput is 1 pair/cycle when out_ready is held high.
- Output hold: while out_valid=1 and out_ready=0, all out_* signals hold stable.
- FSM transitions:
  - IDLE -> DATA on the first accepted bit; the counter becomes 1.
  - DATA: each accepted bit increments the counter. The bit that makes the counter equal FRAME_LEN moves the FSM to TAIL; FRAME_LEN=1 goes IDLE -> TAIL directly.
  - TAIL: when the output slot is free or being freed, generate a tail symbol with u=s1^s2, which forces a=0. out_tail=1 and in_ready=0 throughout TAIL. After 2 tail symbols the state is (0,0) and the FSM returns to IDLE. out_last=1 accompanies the second tail symbol.
- Back-to-back frames: a new frame may be accepted in the same cycle that the last tail pair is accepted.
- Counter: width clog2(FRAME_LEN+1); it clears on return to IDLE.
- Reset mid-frame: the frame is abandoned, with no partial output and no tail.
- in_valid with in_ready=0: ignored; the bit is not consumed.

Optional Feature:
- Macro: RSC_PUNCTURE_EN.
- Defined: the parity of odd-indexed data symbols (index k=0..FRAME_LEN-1) is output as 0 (erasure, zero LLR), giving rate 2/3 on data. out_sys and tail parity are never punctured. The trellis state updates normally.
- Undefined: every parity symbol is emitted.

Decomposition:
- Package rsc_pkg:
  - W and AMP defaults
  - FSM state enum {IDLE, DATA, TAIL}
  - tail length constant TAIL_LEN=2
  - function bpsk_map(bit) -> signed [W-1:0]
- Sub-module rsc_trellis_step (combinational): inputs s1, s2, u; outputs a, p, next state. It is shared with the decoder's branch-metric reference model.

Test Plan:
- Basic frame: FRAME_LEN=4, AMP=1024, bits 1,0,1,1, out_ready=1.
  - out_sys = -1024, +1024, -1024, -1024, +1024(tail), -1024(tail)
  - out_par = -1024, -1024, +1024, +1024, -1024, -1024
  - out_last on the 6th pair; final state (0,0).
- Backpressure: same frame, out_ready toggles 1,0,0,1 repeating -> the out_* signals hold stable while stalled, no pair is lost or duplicated, and in_ready=0 while stalled.
- Termination: random 64-bit frame -> exactly 66 pairs, tail flagged on pairs 65-66, and the trellis state returns to (0,0), checked against the reference model.
- Reset mid-frame: rst_n=0 after 10 bits -> all outputs 0 asynchronously. The next frame encodes from state 0 and matches the model.
- Back-to-back frames: two frames with in_valid held high -> no idle cycle between the last tail pair and the first data pair of frame 2.
- RSC_PUNCTURE_EN: FRAME_LEN=4 vector above -> out_par = -1024, 0, +1024, 0, -1024, -1024; out_sys unchanged.
